// File: rtl/f7_weight_store_if.sv
// Write-stream and read-port bundle between the F7 weight buffer / MAC array and the weight store.
// The master side drives the write stream and read requests; the slave side returns read data and status.
interface f7_weight_store_if #(
    parameter int WD  = 8,
    parameter int NUM = 10
);
    logic                 i_w_en;
    logic [7:0]           i_w_num;
    logic [7:0]           i_w_addr;
    logic [WD-1:0]        i_weight;
    logic                 i_rd_en;
    logic [7:0]           i_rd_addr;
    logic                 o_rd_valid;
    logic [NUM*WD-1:0]    o_rd_weights;
    logic                 o_loaded;
    logic                 o_err;

    modport master (
        output i_w_en, i_w_num, i_w_addr, i_weight, i_rd_en, i_rd_addr,
        input  o_rd_valid, o_rd_weights, o_loaded, o_err
    );

    modport slave (
        input  i_w_en, i_w_num, i_w_addr, i_weight, i_rd_en, i_rd_addr,
        output o_rd_valid, o_rd_weights, o_loaded, o_err
    );
endinterface

// File: rtl/f7_weight_store.sv
// FC-layer-7 weight store: absorbs the per-weight write stream into a NUM x NW array and,
// once a full set is loaded, returns the weights of all neurons for one input address per cycle.
module f7_weight_store #(
    parameter int WD  = 8,
    parameter int NW  = 84,
    parameter int NUM = 10
) (
    input logic              i_sclk,
    input logic              i_rstn,
    f7_weight_store_if.slave bus
);
    localparam int TOTAL = NW * NUM;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int AW    = (NW > 1) ? $clog2(NW) : 1;
    localparam int NAW   = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        READY
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              loaded_q, loaded_d;
    logic              err_q, err_d;
    logic              rd_valid_q, rd_valid_d;
    logic [NUM*WD-1:0] rd_weights_q, rd_weights_d;
    logic [WD-1:0]     mem_q [NUM][NW];

    logic              wr_ok, wr_bad, rd_ok, rd_bad;
    logic [NAW-1:0]    wr_row;
    logic [AW-1:0]     wr_col, rd_col;

    // Request decode: range checks on the 1-based neuron number and the input index.
    always_comb begin
        wr_ok  = bus.i_w_en && (bus.i_w_num != 8'd0) && (bus.i_w_num <= 8'(NUM))
                 && (bus.i_w_addr < 8'(NW));
        wr_bad = bus.i_w_en && !wr_ok;
        rd_ok  = (state_q == READY) && bus.i_rd_en && (bus.i_rd_addr < 8'(NW));
        rd_bad = (state_q == READY) && bus.i_rd_en && !(bus.i_rd_addr < 8'(NW));
        wr_row = NAW'(bus.i_w_num - 8'd1);
        wr_col = AW'(bus.i_w_addr);
        rd_col = AW'(bus.i_rd_addr);
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q | wr_bad | rd_bad;
        rd_valid_d   = rd_ok;
        rd_weights_d = rd_weights_q;

        // Array read uses the pre-write contents, so a colliding write is seen only by later reads.
        if (rd_ok) begin
            for (int n = 0; n < NUM; n++) begin
                rd_weights_d[n*WD +: WD] = mem_q[n][rd_col];
            end
        end

        case (state_q)
            EMPTY: begin
                if (wr_ok) begin
                    cnt_d   = CW'(1);
                    state_d = (TOTAL == 1) ? READY : LOADING;
                end
            end
            LOADING: begin
                if (wr_ok) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q + CW'(1) == CW'(TOTAL)) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                // Any accepted write here is the first weight of a fresh set.
                if (wr_ok) begin
                    cnt_d   = CW'(1);
                    state_d = (TOTAL == 1) ? READY : LOADING;
                end
            end
            default: begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        endcase

        loaded_d = (state_d == READY);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_sclk) begin
        if (!i_rstn) begin
            state_q      <= EMPTY;
            cnt_q        <= '0;
            loaded_q     <= 1'b0;
            err_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_weights_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loaded_q     <= loaded_d;
            err_q        <= err_d;
            rd_valid_q   <= rd_valid_d;
            rd_weights_q <= rd_weights_d;
        end
    end

    // NOTE: the weight array has no reset; contents survive reset and are only replaced by writes.
    always_ff @(posedge i_sclk) begin
        if (i_rstn && wr_ok) begin
            mem_q[wr_row][wr_col] <= bus.i_weight;
        end
    end

    assign bus.o_rd_valid   = rd_valid_q;
    assign bus.o_rd_weights = rd_weights_q;
    assign bus.o_loaded     = loaded_q;
    assign bus.o_err        = err_q;

endmodule
